// File: rtl/stb_seq_ctrl.sv
// stb_seq_ctrl: sequencer for the measurement-unit strobe generator.
// Holds the generator in reset after a software start, waits for its period
// measurement, requests the programmed number of strobes one at a time,
// counts the valid ones and reports a final status with a one-cycle done pulse.
// Optional build macro: STB_SEQ_CTRL_WDT_EN adds a per-phase watchdog that
// ends any wait longer than WDT_CYCLES with status TIMEOUT.
module stb_seq_ctrl #(
   parameter int N_STB_WIDTH = 16,
   parameter int T_CNT_WIDTH = 32,
   parameter int RST_CYCLES  = 4,
   parameter int WDT_CYCLES  = 1048576
) (
   input  logic                   clk_i,
   input  logic                   arstn_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [N_STB_WIDTH-1:0] n_stb_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [1:0]             status_o,
   output logic [N_STB_WIDTH-1:0] stb_cnt_o,
   output logic [T_CNT_WIDTH-1:0] period_o,
   output logic                   gen_arstn_o,
   input  logic                   gen_rdy_i,
   input  logic                   gen_err_i,
   input  logic                   gen_stb_valid_i,
   input  logic [T_CNT_WIDTH-1:0] gen_period_i,
   output logic                   gen_stb_req_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN_RST,
      S_WAIT_RDY,
      S_REQ,
      S_WAIT_CLR,
      S_WAIT_VALID,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_TIMEOUT = 2'b01,
      ST_GEN_ERR = 2'b10,
      ST_ABORT   = 2'b11
   } status_t;

   localparam int RCW = $clog2(RST_CYCLES + 1);

   // Reject parameter values that would make the reset phase or watchdog meaningless.
   if (RST_CYCLES < 1 || WDT_CYCLES < 1) begin : g_param_chk
      $error("stb_seq_ctrl: RST_CYCLES and WDT_CYCLES must be >= 1");
   end

   state_t                 state_q, state_d;
   logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
   logic [N_STB_WIDTH-1:0] n_tgt_q, n_tgt_d;
   logic [N_STB_WIDTH-1:0] stb_cnt_q, stb_cnt_d;
   logic [T_CNT_WIDTH-1:0] period_q, period_d;
   status_t                status_q, status_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   gen_arstn_q, gen_arstn_d;
   logic                   req_q, req_d;
   logic                   early_exit;
   status_t                exit_status;

`ifdef STB_SEQ_CTRL_WDT_EN
   localparam int WCW = $clog2(WDT_CYCLES + 1);

   logic [WCW-1:0] wdt_cnt_q;
   logic           in_wait;
   logic           wdt_expired;

   assign in_wait     = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_CLR) ||
                        (state_q == S_WAIT_VALID);
   assign wdt_expired = in_wait && (wdt_cnt_q == WCW'(WDT_CYCLES - 1));

   // Per-phase watchdog: restarts on every state change, counts only while waiting.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         wdt_cnt_q <= '0;
      end else if (state_d != state_q) begin
         wdt_cnt_q <= '0;
      end else if (in_wait) begin
         wdt_cnt_q <= wdt_cnt_q + WCW'(1);
      end
   end
`endif

   // State and every output register; all outputs come straight from flops.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         n_tgt_q     <= '0;
         stb_cnt_q   <= '0;
         period_q    <= '0;
         status_q    <= ST_OK;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         gen_arstn_q <= 1'b0;
         req_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         n_tgt_q     <= n_tgt_d;
         stb_cnt_q   <= stb_cnt_d;
         period_q    <= period_d;
         status_q    <= status_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         gen_arstn_q <= gen_arstn_d;
         req_q       <= req_d;
      end
   end

   // Next-state logic: early exits by priority, then the normal phase transitions.
   // NOTE: every signal gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      n_tgt_d     = n_tgt_q;
      stb_cnt_d   = stb_cnt_q;
      period_d    = period_q;
      status_d    = status_q;
      early_exit  = 1'b0;
      exit_status = ST_OK;

      if (state_q != S_IDLE && state_q != S_DONE) begin
         if (abort_i) begin
            early_exit  = 1'b1;
            exit_status = ST_ABORT;
         end else if (gen_err_i && state_q != S_GEN_RST) begin
            early_exit  = 1'b1;
            exit_status = ST_GEN_ERR;
`ifdef STB_SEQ_CTRL_WDT_EN
         end else if (wdt_expired) begin
            early_exit  = 1'b1;
            exit_status = ST_TIMEOUT;
`endif
         end
      end

      if (early_exit) begin
         state_d  = S_DONE;
         status_d = exit_status;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  n_tgt_d   = n_stb_i;
                  stb_cnt_d = '0;
                  rst_cnt_d = RCW'(RST_CYCLES);
                  state_d   = S_GEN_RST;
               end
            end
            S_GEN_RST: begin
               rst_cnt_d = rst_cnt_q - RCW'(1);
               if (rst_cnt_q == RCW'(1)) begin
                  state_d = S_WAIT_RDY;
               end
            end
            S_WAIT_RDY: begin
               if (gen_rdy_i) begin
                  period_d = gen_period_i;
                  if (n_tgt_q == '0) begin
                     state_d  = S_DONE;
                     status_d = ST_OK;
                  end else begin
                     state_d = S_REQ;
                  end
               end
            end
            S_REQ: begin
               state_d = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
               // The generator drops valid once it has taken the new request.
               if (!gen_stb_valid_i) begin
                  state_d = S_WAIT_VALID;
               end
            end
            S_WAIT_VALID: begin
               if (gen_stb_valid_i) begin
                  stb_cnt_d = stb_cnt_q + N_STB_WIDTH'(1);
                  if (stb_cnt_q + N_STB_WIDTH'(1) == n_tgt_q) begin
                     state_d  = S_DONE;
                     status_d = ST_OK;
                  end else begin
                     state_d = S_REQ;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state so each output is a plain flop.
   always_comb begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      req_d  = (state_d == S_REQ);
      case (state_d)
         S_WAIT_RDY, S_REQ, S_WAIT_CLR, S_WAIT_VALID: gen_arstn_d = 1'b1;
         // An abort straight out of GEN_RST keeps the generator in reset.
         S_DONE:  gen_arstn_d = gen_arstn_q;
         default: gen_arstn_d = 1'b0;
      endcase
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign status_o      = status_q;
   assign stb_cnt_o     = stb_cnt_q;
   assign period_o      = period_q;
   assign gen_arstn_o   = gen_arstn_q;
   assign gen_stb_req_o = req_q;

endmodule

// File: tb/tb_stb_seq_ctrl.sv
// Self-checking bench for stb_seq_ctrl: directed test-plan sequences plus
// randomized sequences, each compared against outcomes computed from the
// sequencing rules (strobe count, status, period, pulse counts, timing).
module tb_stb_seq_ctrl;

   localparam int NW  = 16;
   localparam int TW  = 32;
   localparam int RST = 4;
`ifdef STB_SEQ_CTRL_WDT_EN
   localparam int WDT = 64;
`else
   localparam int WDT = 1048576;
`endif

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_GEN_ERR = 2'b10;
   localparam logic [1:0] ST_ABORT   = 2'b11;

   logic          clk_i = 1'b0;
   logic          arstn_i = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [NW-1:0] n_stb_i = '0;
   logic          busy_o;
   logic          done_o;
   logic [1:0]    status_o;
   logic [NW-1:0] stb_cnt_o;
   logic [TW-1:0] period_o;
   logic          gen_arstn_o;
   logic          gen_rdy_i = 1'b0;
   logic          gen_err_i = 1'b0;
   logic          gen_stb_valid_i = 1'b0;
   logic [TW-1:0] gen_period_i = '0;
   logic          gen_stb_req_o;

   int total = 0;
   int bad   = 0;
   int req_hi  = 0;
   int done_hi = 0;
   logic [TW-1:0] model_period = '0;

   stb_seq_ctrl #(
      .N_STB_WIDTH(NW),
      .T_CNT_WIDTH(TW),
      .RST_CYCLES (RST),
      .WDT_CYCLES (WDT)
   ) dut (
      .clk_i          (clk_i),
      .arstn_i        (arstn_i),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .n_stb_i        (n_stb_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .status_o       (status_o),
      .stb_cnt_o      (stb_cnt_o),
      .period_o       (period_o),
      .gen_arstn_o    (gen_arstn_o),
      .gen_rdy_i      (gen_rdy_i),
      .gen_err_i      (gen_err_i),
      .gen_stb_valid_i(gen_stb_valid_i),
      .gen_period_i   (gen_period_i),
      .gen_stb_req_o  (gen_stb_req_o)
   );

   always #5 clk_i = ~clk_i;

   // Count request and done cycles independently of the directed steps.
   always @(negedge clk_i) begin
      if (arstn_i) begin
         if (gen_stb_req_o) req_hi++;
         if (done_o) done_hi++;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full start-to-idle sequence with a behavioural generator.
   // err_at >= 0 raises gen_err_i instead of valid for strobe number err_at.
   task automatic run_seq(input string tag, input int n, input int rdy_dly, input int v_dly,
                          input logic [TW-1:0] per, input int err_at, input bit abort_rdy);
      int         req0, done0, exp_req, exp_cnt;
      logic [1:0] exp_st;
      if (abort_rdy) begin
         exp_st = ST_ABORT;   exp_cnt = 0;      exp_req = 0;
      end else if (err_at >= 0 && err_at < n) begin
         exp_st = ST_GEN_ERR; exp_cnt = err_at; exp_req = err_at + 1;
      end else begin
         exp_st = ST_OK;      exp_cnt = n;      exp_req = n;
      end
      req0 = req_hi;
      done0 = done_hi;
      gen_rdy_i = 1'b0; gen_stb_valid_i = 1'b0; gen_err_i = 1'b0; abort_i = 1'b0;
      n_stb_i = NW'(n);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk({tag, ":busy"}, 64'(busy_o), 64'd1);
      chk({tag, ":cnt_clr"}, 64'(stb_cnt_o), 64'd0);
      chk({tag, ":period_hold"}, 64'(period_o), 64'(model_period));
      repeat (RST - 1) tick();
      chk({tag, ":arstn_low"}, 64'(gen_arstn_o), 64'd0);
      tick();
      chk({tag, ":arstn_rise"}, 64'(gen_arstn_o), 64'd1);
      repeat (rdy_dly) tick();
      chk({tag, ":no_req_before_rdy"}, 64'(req_hi - req0), 64'd0);
      if (abort_rdy) begin
         abort_i = 1'b1; gen_err_i = 1'b1;
         tick();
         abort_i = 1'b0; gen_err_i = 1'b0;
      end else begin
         gen_period_i = per;
         gen_rdy_i = 1'b1;
         tick();
         model_period = per;
         for (int s = 0; s < n; s++) begin
            chk({tag, ":req"}, 64'(gen_stb_req_o), 64'd1);
            chk({tag, ":cnt_run"}, 64'(stb_cnt_o), 64'(s));
            gen_stb_valid_i = 1'b0;
            tick();
            chk({tag, ":req_1w"}, 64'(gen_stb_req_o), 64'd0);
            repeat (v_dly - 1) tick();
            if (s == err_at) begin
               gen_err_i = 1'b1;
               tick();
               gen_err_i = 1'b0;
               break;
            end
            gen_stb_valid_i = 1'b1;
            tick();
         end
      end
      chk({tag, ":done"}, 64'(done_o), 64'd1);
      chk({tag, ":status"}, 64'(status_o), 64'(exp_st));
      chk({tag, ":cnt"}, 64'(stb_cnt_o), 64'(exp_cnt));
      chk({tag, ":req_done"}, 64'(gen_stb_req_o), 64'd0);
      gen_stb_valid_i = 1'b0;
      gen_rdy_i = 1'b0;
      tick();
      chk({tag, ":idle_busy"}, 64'(busy_o), 64'd0);
      chk({tag, ":idle_done"}, 64'(done_o), 64'd0);
      chk({tag, ":idle_arstn"}, 64'(gen_arstn_o), 64'd0);
      chk({tag, ":idle_status"}, 64'(status_o), 64'(exp_st));
      chk({tag, ":idle_cnt"}, 64'(stb_cnt_o), 64'(exp_cnt));
      chk({tag, ":idle_period"}, 64'(period_o), 64'(model_period));
      chk({tag, ":req_pulses"}, 64'(req_hi - req0), 64'(exp_req));
      chk({tag, ":done_pulses"}, 64'(done_hi - done0), 64'd1);
   endtask

   initial begin
      int done0;
      // Reset values while arstn_i is held low.
      repeat (2) tick();
      chk("rst:busy", 64'(busy_o), 64'd0);
      chk("rst:done", 64'(done_o), 64'd0);
      chk("rst:status", 64'(status_o), 64'(ST_OK));
      chk("rst:cnt", 64'(stb_cnt_o), 64'd0);
      chk("rst:period", 64'(period_o), 64'd0);
      chk("rst:arstn", 64'(gen_arstn_o), 64'd0);
      chk("rst:req", 64'(gen_stb_req_o), 64'd0);
      arstn_i = 1'b1;
      tick();

      run_seq("nominal", 3, 100, 5, 32'd1000, -1, 1'b0);
      run_seq("zero", 0, 7, 5, 32'd42, -1, 1'b0);
      run_seq("gen_err", 4, 10, 5, 32'd555, 1, 1'b0);
      run_seq("abort_err", 2, 5, 5, 32'd9, -1, 1'b1);

      for (int i = 0; i < 6; i++) begin
         int n, e;
         n = int'($urandom_range(1, 6));
         e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         run_seq("rand", n, int'($urandom_range(0, 20)), int'($urandom_range(2, 8)),
                 $urandom(), e, 1'b0);
      end

      // start_i held high: ignored mid-run, re-triggers once back in IDLE.
      gen_rdy_i = 1'b1; gen_period_i = 32'h0000_1234; n_stb_i = '0; start_i = 1'b1;
      tick();
      chk("retrig:busy", 64'(busy_o), 64'd1);
      repeat (RST + 1) tick();
      model_period = 32'h0000_1234;
      chk("retrig:done", 64'(done_o), 64'd1);
      chk("retrig:status", 64'(status_o), 64'(ST_OK));
      chk("retrig:period", 64'(period_o), 64'(model_period));
      tick();
      chk("retrig:idle", 64'(busy_o), 64'd0);
      tick();
      chk("retrig:restart", 64'(busy_o), 64'd1);
      start_i = 1'b0; gen_rdy_i = 1'b0; abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("retrig:abort_done", 64'(done_o), 64'd1);
      chk("retrig:abort_status", 64'(status_o), 64'(ST_ABORT));
      tick();
      chk("retrig:abort_idle", 64'(busy_o), 64'd0);

      // Generator never becomes ready.
      done0 = done_hi;
      n_stb_i = NW'(1); start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (RST) tick();
      chk("wdt:wait_rdy", 64'(gen_arstn_o), 64'd1);
`ifdef STB_SEQ_CTRL_WDT_EN
      repeat (WDT - 1) tick();
      chk("wdt:not_yet", 64'(done_o), 64'd0);
      tick();
      chk("wdt:done", 64'(done_o), 64'd1);
      chk("wdt:status", 64'(status_o), 64'(ST_TIMEOUT));
      chk("wdt:period", 64'(period_o), 64'(model_period));
      tick();
      chk("wdt:idle", 64'(busy_o), 64'd0);
`else
      repeat (10000) tick();
      chk("nowdt:busy", 64'(busy_o), 64'd1);
      chk("nowdt:no_done", 64'(done_hi - done0), 64'd0);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("nowdt:abort_status", 64'(status_o), 64'(ST_ABORT));
      tick();
      chk("nowdt:idle", 64'(busy_o), 64'd0);
`endif

      // Asynchronous reset during WAIT_CLR.
      done0 = done_hi;
      n_stb_i = NW'(3); start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (RST) tick();
      gen_period_i = 32'd777; gen_rdy_i = 1'b1;
      tick();
      chk("mrst:req", 64'(gen_stb_req_o), 64'd1);
      gen_stb_valid_i = 1'b0;
      tick();
      #2;
      arstn_i = 1'b0;
      #1;
      chk("mrst:busy", 64'(busy_o), 64'd0);
      chk("mrst:done", 64'(done_o), 64'd0);
      chk("mrst:status", 64'(status_o), 64'(ST_OK));
      chk("mrst:cnt", 64'(stb_cnt_o), 64'd0);
      chk("mrst:period", 64'(period_o), 64'd0);
      chk("mrst:arstn", 64'(gen_arstn_o), 64'd0);
      chk("mrst:req_low", 64'(gen_stb_req_o), 64'd0);
      gen_rdy_i = 1'b0;
      model_period = '0;
      repeat (2) tick();
      arstn_i = 1'b1;
      repeat (2) tick();
      chk("mrst:no_done", 64'(done_hi - done0), 64'd0);
      chk("mrst:idle", 64'(busy_o), 64'd0);
      run_seq("after_rst", 2, 3, 4, 32'd31337, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stb_seq_ctrl.md
# stb_seq_ctrl

Sequencer for the strobe generator in the measurement unit. On a software start it resets the generator and waits for its period measurement to complete. It then requests a programmed number of strobes one at a time, counts the acknowledged (valid) strobes, and reports a final status. It sits between the register/CPU side and the generator and owns the generator's reset and strobe-request inputs.

## Interface
- `N_STB_WIDTH`, 16: width of the strobe-count request and counter.
- `T_CNT_WIDTH`, 32: width of the generator period bus.
- `RST_CYCLES`, 4: cycles the generator is held in reset after start, ≥1.
- `WDT_CYCLES`, 1048576: per-phase watchdog limit, used only with `STB_SEQ_CTRL_WDT_EN`.
- `clk_i` in 1: clock.
- `arstn_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start request, level sampled in IDLE only.
- `abort_i` in 1: abort the running sequence.
- `n_stb_i` in N_STB_WIDTH: number of strobes to request, latched on start.
- `busy_o` out 1: sequence in progress (any state except IDLE).
- `done_o` out 1: one-cycle completion pulse.
- `status_o` out 2: result of the last sequence. 00 OK, 01 TIMEOUT, 10 GEN_ERR, 11 ABORT.
- `stb_cnt_o` out N_STB_WIDTH: valid strobes completed in the current or last sequence.
- `period_o` out T_CNT_WIDTH: generator period latched when the generator reports ready.
- `gen_arstn_o` out 1: generator reset, active-low, registered.
- `gen_rdy_i` in 1: generator ready.
- `gen_err_i` in 1: generator error.
- `gen_stb_valid_i` in 1: generator strobe valid.
- `gen_period_i` in T_CNT_WIDTH: generator period.
- `gen_stb_req_o` out 1: generator strobe request, registered.

## Operation
- All outputs and state are registered. Reset values: `busy_o`=0, `done_o`=0, `status_o`=00, `stb_cnt_o`=0, `period_o`=0, `gen_arstn_o`=0, `gen_stb_req_o`=0. State resets to IDLE.
- **IDLE**: `gen_arstn_o`=0.
  - If `start_i`=1: latch `n_stb_i` into `n_tgt`, clear `stb_cnt_o`, load the reset counter with RST_CYCLES, and go to GEN_RST.
- **GEN_RST**: `gen_arstn_o`=0. Decrement the reset counter. At 0, go to WAIT_RDY with `gen_arstn_o`=1.
- **WAIT_RDY**: wait for `gen_rdy_i`=1.
  - Then latch `gen_period_i` into `period_o`.
  - Go to DONE/OK if `n_tgt`=0, else go to REQ.
- **REQ**: `gen_stb_req_o`=1 for exactly one cycle, then go to WAIT_CLR.
- **WAIT_CLR**: `gen_stb_req_o`=0. Wait for `gen_stb_valid_i`=0 (the generator clearing its pending flag), then go to WAIT_VALID.
- **WAIT_VALID**: wait for `gen_stb_valid_i`=1, then increment `stb_cnt_o`.
  - If `stb_cnt_o`+1 == `n_tgt`, go to DONE/OK.
  - Otherwise go to REQ.
- **DONE**: for one cycle, `done_o`=1, `status_o` is updated and `gen_stb_req_o`=0. Then go to IDLE.
  - `status_o` holds until the next DONE.
  - `stb_cnt_o` and `period_o` hold until the next start.
- **Early exits** apply in any state except IDLE and DONE, evaluated in priority order:
  - `abort_i`=1 → DONE/ABORT.
  - else `gen_err_i`=1, outside GEN_RST → DONE/GEN_ERR.
  - else watchdog expiry → DONE/TIMEOUT.
  - else the normal transition.
- An abort or error during REQ still lets the already-issued request remain one cycle wide.
- `start_i` outside IDLE is ignored. `start_i` held high re-triggers after DONE→IDLE.
- `stb_cnt_o` never exceeds `n_tgt`. There is no wrap: `n_tgt`=2^N_STB_WIDTH−1 is a valid maximum.

## Timing
- Start at cycle 0 in IDLE: GEN_RST occupies cycles 1..RST_CYCLES, and `gen_arstn_o` rises at cycle RST_CYCLES+1.
- Generator ready to `gen_stb_req_o` high takes 1 cycle: the WAIT_RDY→REQ edge.
- `gen_stb_valid_i` rising in WAIT_VALID leads to the next `gen_stb_req_o` 1 cycle later. Minimum request spacing is 3 cycles (REQ, WAIT_CLR, WAIT_VALID).
- The completing event is followed by `done_o` one cycle later.
- `arstn_i` asserted mid-sequence: all outputs take their reset values immediately (asynchronous). `gen_arstn_o` falls in the same instant, and no `done_o` is produced.

## Configuration
- `STB_SEQ_CTRL_WDT_EN` defined: a per-phase watchdog is built in.
  - The counter clears on every state change.
  - It counts in WAIT_RDY, WAIT_CLR and WAIT_VALID.
  - When it reaches WDT_CYCLES, the block goes to DONE/TIMEOUT.
- `STB_SEQ_CTRL_WDT_EN` not defined: no watchdog logic exists, waits are unbounded, and status 01 is never produced.

## Test plan
- Nominal run: `n_stb_i`=3, generator ready 100 cycles after release with `gen_period_i`=1000, valid returned 5 cycles after each request → exactly 3 one-cycle `gen_stb_req_o` pulses, `stb_cnt_o`=3, `period_o`=1000, `status_o`=00, one `done_o`.
- Zero strobes: `n_stb_i`=0 → no `gen_stb_req_o` pulse, `done_o` 1 cycle after `gen_rdy_i`, `status_o`=00, `stb_cnt_o`=0.
- Generator error: `gen_err_i` rises in WAIT_VALID after 1 of 4 strobes → `status_o`=10, `stb_cnt_o`=1, `gen_arstn_o` low in IDLE.
- Simultaneous abort and error: `abort_i`=1 and `gen_err_i`=1 in the same cycle during WAIT_RDY → `status_o`=11.
- Watchdog (with `STB_SEQ_CTRL_WDT_EN`, WDT_CYCLES=64): `gen_rdy_i` never rises → `done_o` 64 cycles after WAIT_RDY entry, `status_o`=01. Without the macro, still busy after 10000 cycles.
- Mid-run reset: `arstn_i` pulsed low during WAIT_CLR → all outputs at reset values, no `done_o`. A new start then completes normally with `n_stb_i`=2.
